// File: rtl/int_mult_add_pipe.sv
// NUM_MULT-lane integer dot product feeding a saturating/wrapping accumulator; latency IN_REG+PIPE_REGS+1.
// No ready handshake: i_ce=0 freezes every stage in place and suppresses o_valid.
module int_mult_add_pipe #(
    parameter int INT_SIZE   = 8,
    parameter int NUM_MULT   = 4,
    parameter int UNSIGNED_A = 0,
    parameter int UNSIGNED_B = 0,
    parameter int IN_REG     = 1,
    parameter int PIPE_REGS  = 2,
    parameter int DOUT_SIZE  = 48,
    parameter int SATURATE   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_ce,
    input  logic                         i_valid,
    input  logic                         i_load,
    input  logic [NUM_MULT*INT_SIZE-1:0] i_din_a,
    input  logic [NUM_MULT*INT_SIZE-1:0] i_din_b,
    output logic                         o_valid,
    output logic [DOUT_SIZE-1:0]         o_dout,
    output logic                         o_overflow,
    output logic [CNT_W-1:0]             o_count
);

    localparam int IW = NUM_MULT * INT_SIZE;
    localparam int PW = 2 * INT_SIZE + 2;
    localparam int SW = PW + $clog2(NUM_MULT);
    localparam int XW = DOUT_SIZE + 1;
    localparam logic signed [DOUT_SIZE-1:0] D_MAX = {1'b0, {(DOUT_SIZE-1){1'b1}}};
    localparam logic signed [DOUT_SIZE-1:0] D_MIN = {1'b1, {(DOUT_SIZE-1){1'b0}}};

    if (INT_SIZE < 3 || INT_SIZE > 16) begin : g_bad_int
        $error("INT_SIZE out of range");
    end
    if (NUM_MULT < 1 || NUM_MULT > 32) begin : g_bad_mult
        $error("NUM_MULT out of range");
    end
    if (PIPE_REGS < 0 || PIPE_REGS > 3) begin : g_bad_pipe
        $error("PIPE_REGS out of range");
    end
    if (DOUT_SIZE < SW || DOUT_SIZE > 64) begin : g_bad_dout
        $error("DOUT_SIZE must cover the full dot-product width and be at most 64");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("CNT_W out of range");
    end

    logic [IW-1:0] s0_a, s0_b;
    logic          s0_vld, s0_ld;

    if (IN_REG != 0) begin : g_in_reg
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                s0_a   <= '0;
                s0_b   <= '0;
                s0_vld <= 1'b0;
                s0_ld  <= 1'b0;
            end else if (i_ce) begin
                s0_a   <= i_din_a;
                s0_b   <= i_din_b;
                s0_vld <= i_valid;
                s0_ld  <= i_valid & i_load;
            end
        end
    end else begin : g_in_bypass
        always_comb begin
            s0_a   = i_din_a;
            s0_b   = i_din_b;
            s0_vld = i_valid;
            s0_ld  = i_valid & i_load;
        end
    end

    // Operands widened by one bit so signed and unsigned lanes share one exact multiplier.
    logic signed [INT_SIZE:0] a_x [NUM_MULT];
    logic signed [INT_SIZE:0] b_x [NUM_MULT];
    logic signed [PW-1:0]     prod [NUM_MULT];
    logic signed [SW-1:0]     tree_sum;

    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < NUM_MULT; i++) begin
            a_x[i] = (UNSIGNED_A != 0) ? {1'b0, s0_a[i*INT_SIZE +: INT_SIZE]}
                                       : {s0_a[i*INT_SIZE+INT_SIZE-1], s0_a[i*INT_SIZE +: INT_SIZE]};
            b_x[i] = (UNSIGNED_B != 0) ? {1'b0, s0_b[i*INT_SIZE +: INT_SIZE]}
                                       : {s0_b[i*INT_SIZE+INT_SIZE-1], s0_b[i*INT_SIZE +: INT_SIZE]};
            prod[i]  = PW'(a_x[i]) * PW'(b_x[i]);
            tree_sum = tree_sum + SW'(prod[i]);
        end
    end

    logic signed [SW-1:0] acc_sum;
    logic                 acc_vld, acc_ld;

    if (PIPE_REGS == 0) begin : g_no_pipe
        always_comb begin
            acc_sum = tree_sum;
            acc_vld = s0_vld;
            acc_ld  = s0_ld;
        end
    end else begin : g_pipe
        logic signed [SW-1:0]  p_sum [PIPE_REGS];
        logic [PIPE_REGS-1:0]  p_vld, p_ld;

        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                for (int k = 0; k < PIPE_REGS; k++) p_sum[k] <= '0;
                p_vld <= '0;
                p_ld  <= '0;
            end else if (i_ce) begin
                p_sum[0] <= tree_sum;
                p_vld[0] <= s0_vld;
                p_ld[0]  <= s0_ld;
                for (int k = 1; k < PIPE_REGS; k++) begin
                    p_sum[k] <= p_sum[k-1];
                    p_vld[k] <= p_vld[k-1];
                    p_ld[k]  <= p_ld[k-1];
                end
            end
        end

        always_comb begin
            acc_sum = p_sum[PIPE_REGS-1];
            acc_vld = p_vld[PIPE_REGS-1];
            acc_ld  = p_ld[PIPE_REGS-1];
        end
    end

    // One guard bit above the accumulator exposes signed overflow as a top-two-bit disagreement.
    logic signed [DOUT_SIZE-1:0] acc_q, acc_nxt;
    logic signed [XW-1:0]        tot;
    logic                        ovf;

    always_comb begin
        tot     = XW'(acc_q) + XW'(acc_sum);
        ovf     = tot[XW-1] != tot[XW-2];
        acc_nxt = tot[DOUT_SIZE-1:0];
        if (ovf && SATURATE != 0) acc_nxt = tot[XW-1] ? D_MIN : D_MAX;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            acc_q      <= '0;
            o_overflow <= 1'b0;
            o_count    <= '0;
            o_valid    <= 1'b0;
        end else if (!i_ce) begin
            o_valid <= 1'b0;
        end else begin
            o_valid <= acc_vld;
            if (acc_vld) begin
                if (acc_ld) begin
                    acc_q      <= DOUT_SIZE'(acc_sum);
                    o_count    <= CNT_W'(1);
                    o_overflow <= 1'b0;
                end else begin
                    acc_q      <= acc_nxt;
                    o_overflow <= o_overflow | ovf;
                    if (o_count != '1) o_count <= o_count + 1'b1;
                end
            end
        end
    end

    assign o_dout = acc_q;

endmodule

// File: tb/tb_int_mult_add_pipe.sv
// Directed bench for int_mult_add_pipe across four parameter sets: default signed,
// unsigned lanes, narrow saturating accumulator, and zero-register minimum latency.
module tb_int_mult_add_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce0 = 1'b1;
    logic ce_on = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    // u0: defaults
    logic        v0 = 0, ld0 = 0, ov0, of0;
    logic [31:0] a0 = '0, b0 = '0;
    logic [47:0] d0;
    logic [15:0] c0;
    // u1: unsigned lanes
    logic        v1 = 0, ld1 = 0, ov1, of1;
    logic [31:0] a1 = '0, b1 = '0;
    logic [47:0] d1;
    logic [15:0] c1;
    // u2: single lane, 18-bit saturating accumulator
    logic        v2 = 0, ld2 = 0, ov2, of2;
    logic [7:0]  a2 = '0, b2 = '0;
    logic [17:0] d2;
    logic [15:0] c2;
    // u3: no input register, no pipeline registers
    logic        v3 = 0, ld3 = 0, ov3, of3;
    logic [31:0] a3 = '0, b3 = '0;
    logic [47:0] d3;
    logic [15:0] c3;

    int_mult_add_pipe u0 (
        .i_clk(clk), .i_reset(rst), .i_ce(ce0), .i_valid(v0), .i_load(ld0),
        .i_din_a(a0), .i_din_b(b0), .o_valid(ov0), .o_dout(d0), .o_overflow(of0), .o_count(c0));

    int_mult_add_pipe #(.UNSIGNED_A(1), .UNSIGNED_B(1)) u1 (
        .i_clk(clk), .i_reset(rst), .i_ce(ce_on), .i_valid(v1), .i_load(ld1),
        .i_din_a(a1), .i_din_b(b1), .o_valid(ov1), .o_dout(d1), .o_overflow(of1), .o_count(c1));

    int_mult_add_pipe #(.NUM_MULT(1), .DOUT_SIZE(18)) u2 (
        .i_clk(clk), .i_reset(rst), .i_ce(ce_on), .i_valid(v2), .i_load(ld2),
        .i_din_a(a2), .i_din_b(b2), .o_valid(ov2), .o_dout(d2), .o_overflow(of2), .o_count(c2));

    int_mult_add_pipe #(.IN_REG(0), .PIPE_REGS(0)) u3 (
        .i_clk(clk), .i_reset(rst), .i_ce(ce_on), .i_valid(v3), .i_load(ld3),
        .i_din_a(a3), .i_din_b(b3), .o_valid(ov3), .o_dout(d3), .o_overflow(of3), .o_count(c3));

    function automatic logic [31:0] pack4(input int l0, input int l1, input int l2, input int l3);
        return {l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        {v0, ld0, v1, ld1, v2, ld2, v3, ld3} = '0;
        ce0 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++; if (d0 !== 48'd0) begin n_bad++; $display("FAIL reset_dout0: got %0d want 0", d0); end
        n_vec++; if (c0 !== 16'd0) begin n_bad++; $display("FAIL reset_count0: got %0d want 0", c0); end
        n_vec++; if (ov0 !== 1'b0) begin n_bad++; $display("FAIL reset_valid0: got %b want 0", ov0); end
        n_vec++; if (of0 !== 1'b0) begin n_bad++; $display("FAIL reset_ovf0: got %b want 0", of0); end
        n_vec++; if (d2 !== 18'd0) begin n_bad++; $display("FAIL reset_dout2: got %0d want 0", d2); end
        n_vec++; if (ov3 !== 1'b0) begin n_bad++; $display("FAIL reset_valid3: got %b want 0", ov3); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        for (int e = 1; e <= 6; e++) begin
            v0 = (e == 1); ld0 = (e == 1);
            a0 = pack4(1, -2, 3, -4); b0 = pack4(5, 6, 7, 8);
            @(negedge clk);
            n_vec++; if (ov0 !== (e == 4)) begin n_bad++; $display("FAIL basic_valid e%0d: got %b want %b", e, ov0, e == 4); end
            if (e >= 4) begin
                n_vec++; if (d0 !== 48'(-18)) begin n_bad++; $display("FAIL basic_dout e%0d: got %0d want -18", e, $signed(d0)); end
                n_vec++; if (c0 !== 16'd1) begin n_bad++; $display("FAIL basic_count e%0d: got %0d want 1", e, c0); end
            end
        end
    endtask

    task automatic test_accumulate();
        for (int e = 1; e <= 7; e++) begin
            v0 = (e <= 3); ld0 = (e == 1);
            a0 = pack4(127, 127, 127, 127); b0 = pack4(127, 127, 127, 127);
            @(negedge clk);
            n_vec++; if (ov0 !== (e >= 4 && e <= 6)) begin n_bad++; $display("FAIL acc_valid e%0d: got %b", e, ov0); end
            if (e >= 4) begin
                longint k = (e == 7) ? 3 : e - 3;
                n_vec++; if (d0 !== 48'(64516 * k)) begin n_bad++; $display("FAIL acc_dout e%0d: got %0d want %0d", e, $signed(d0), 64516 * k); end
                n_vec++; if (c0 !== 16'(k)) begin n_bad++; $display("FAIL acc_count e%0d: got %0d want %0d", e, c0, k); end
            end
        end
    endtask

    task automatic test_stall();
        bit exp_v [11] = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0};
        int exp_d [11] = '{0, 0, 0, 4, 12, 12, 12, 12, 24, 40, 40};
        int exp_c [11] = '{0, 0, 0, 1, 2, 2, 2, 2, 3, 4, 4};
        do_reset();
        for (int e = 1; e <= 11; e++) begin
            ce0 = !(e >= 6 && e <= 8);
            v0 = (e <= 4); ld0 = (e == 1);
            a0 = pack4(e, e, e, e); b0 = pack4(1, 1, 1, 1);
            @(negedge clk);
            n_vec++; if (ov0 !== exp_v[e-1]) begin n_bad++; $display("FAIL stall_valid e%0d: got %b want %b", e, ov0, exp_v[e-1]); end
            n_vec++; if (d0 !== 48'(exp_d[e-1])) begin n_bad++; $display("FAIL stall_dout e%0d: got %0d want %0d", e, $signed(d0), exp_d[e-1]); end
            n_vec++; if (c0 !== 16'(exp_c[e-1])) begin n_bad++; $display("FAIL stall_count e%0d: got %0d want %0d", e, c0, exp_c[e-1]); end
        end
        ce0 = 1'b1;
    endtask

    task automatic test_unsigned();
        do_reset();
        for (int e = 1; e <= 4; e++) begin
            v0 = (e == 1); ld0 = (e == 1); v1 = (e == 1); ld1 = (e == 1);
            a0 = pack4(255, 255, 255, 255); b0 = a0; a1 = a0; b1 = a0;
            @(negedge clk);
        end
        n_vec++; if (ov1 !== 1'b1) begin n_bad++; $display("FAIL uns_valid: got %b want 1", ov1); end
        n_vec++; if (d1 !== 48'd260100) begin n_bad++; $display("FAIL uns_dout: got %0d want 260100", $signed(d1)); end
        n_vec++; if (d0 !== 48'd4) begin n_bad++; $display("FAIL signed_ff_dout: got %0d want 4", $signed(d0)); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int e = 1; e <= 14; e++) begin
            v2 = (e <= 10); ld2 = (e == 1 || e == 10);
            a2 = (e == 10) ? 8'd1 : 8'h80; b2 = a2;
            @(negedge clk);
            n_vec++; if (ov2 !== (e >= 4 && e <= 13)) begin n_bad++; $display("FAIL sat_valid e%0d: got %b", e, ov2); end
            if (e >= 4 && e <= 13) begin
                int k = e - 3;
                int ed = (k <= 7) ? 16384 * k : (k <= 9) ? 131071 : 1;
                n_vec++; if (d2 !== 18'(ed)) begin n_bad++; $display("FAIL sat_dout k%0d: got %0d want %0d", k, $signed(d2), ed); end
                n_vec++; if (of2 !== (k == 8 || k == 9)) begin n_bad++; $display("FAIL sat_ovf k%0d: got %b want %b", k, of2, k == 8 || k == 9); end
                n_vec++; if (c2 !== 16'((k <= 9) ? k : 1)) begin n_bad++; $display("FAIL sat_count k%0d: got %0d", k, c2); end
            end
        end
    endtask

    task automatic test_saturate_min();
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            v2 = (e <= 9); ld2 = (e == 1);
            a2 = 8'h80; b2 = 8'd127;
            @(negedge clk);
            if (e >= 4) begin
                int k = e - 3;
                int ed = (k <= 8) ? -16256 * k : -131072;
                n_vec++; if (d2 !== 18'(ed)) begin n_bad++; $display("FAIL satmin_dout k%0d: got %0d want %0d", k, $signed(d2), ed); end
                n_vec++; if (of2 !== (k == 9)) begin n_bad++; $display("FAIL satmin_ovf k%0d: got %b want %b", k, of2, k == 9); end
            end
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int e = 1; e <= 6; e++) begin
            v0 = (e == 1 || e == 5 || e == 6); ld0 = (e == 1);
            a0 = pack4(1, 1, 1, 1); b0 = pack4(2, 2, 2, 2);
            @(negedge clk);
            if (e == 4) begin
                n_vec++; if (d0 !== 48'd8) begin n_bad++; $display("FAIL mid_pre_dout: got %0d want 8", $signed(d0)); end
            end
        end
        v0 = 1'b0; ld0 = 1'b0;
        rst = 1'b1;
        #1;
        n_vec++; if (d0 !== 48'd0) begin n_bad++; $display("FAIL mid_rst_dout: got %0d want 0", $signed(d0)); end
        n_vec++; if (c0 !== 16'd0) begin n_bad++; $display("FAIL mid_rst_count: got %0d want 0", c0); end
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            @(negedge clk);
            n_vec++; if (ov0 !== 1'b0) begin n_bad++; $display("FAIL mid_ghost_valid e%0d: got %b want 0", e, ov0); end
        end
        for (int e = 1; e <= 4; e++) begin
            v0 = (e == 1); ld0 = 1'b0;
            a0 = pack4(1, 1, 1, 1); b0 = pack4(3, 3, 3, 3);
            @(negedge clk);
        end
        n_vec++; if (ov0 !== 1'b1) begin n_bad++; $display("FAIL mid_post_valid: got %b want 1", ov0); end
        n_vec++; if (d0 !== 48'd12) begin n_bad++; $display("FAIL mid_post_dout: got %0d want 12", $signed(d0)); end
        n_vec++; if (c0 !== 16'd1) begin n_bad++; $display("FAIL mid_post_count: got %0d want 1", c0); end
    endtask

    task automatic test_latency1();
        bit v_in [4]  = '{1, 1, 0, 1};
        bit ld_in [4] = '{1, 0, 1, 0};
        int av [4]    = '{1, -1, 5, 2};
        int exp_d [4] = '{10, 6, 6, 14};
        int exp_c [4] = '{1, 2, 2, 3};
        do_reset();
        for (int e = 1; e <= 4; e++) begin
            v3 = v_in[e-1]; ld3 = ld_in[e-1];
            a3 = pack4(av[e-1], av[e-1], av[e-1], av[e-1]);
            b3 = (e == 1) ? pack4(1, 2, 3, 4) : pack4(1, 1, 1, 1);
            @(negedge clk);
            n_vec++; if (ov3 !== v_in[e-1]) begin n_bad++; $display("FAIL lat1_valid e%0d: got %b want %b", e, ov3, v_in[e-1]); end
            n_vec++; if (d3 !== 48'(exp_d[e-1])) begin n_bad++; $display("FAIL lat1_dout e%0d: got %0d want %0d", e, $signed(d3), exp_d[e-1]); end
            n_vec++; if (c3 !== 16'(exp_c[e-1])) begin n_bad++; $display("FAIL lat1_count e%0d: got %0d want %0d", e, c3, exp_c[e-1]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_accumulate();
        test_stall();
        test_unsigned();
        test_saturate();
        test_saturate_min();
        test_reset_midstream();
        test_latency1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
